// File: rtl/msrv32_pkg.sv
// Shared encodings for the msrv32 machine-mode trap controller:
// FSM states, trap cause codes, pc_src selects and SYSTEM-opcode constants.
package msrv32_pkg;

  typedef enum logic [1:0] {
    ST_RESET       = 2'b00,
    ST_OPERATING   = 2'b01,
    ST_TRAP_TAKEN  = 2'b10,
    ST_TRAP_RETURN = 2'b11
  } state_t;

  // Interrupt cause codes (mcause with interrupt bit set)
  localparam logic [3:0] CAUSE_M_EXT_IRQ   = 4'd11;
  localparam logic [3:0] CAUSE_M_SW_IRQ    = 4'd3;
  localparam logic [3:0] CAUSE_M_TIMER_IRQ = 4'd7;

  // Exception cause codes
  localparam logic [3:0] CAUSE_INSTR_MISALIGNED = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL_INSTR    = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
  localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;
  localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;

  localparam logic [1:0] PC_BOOT    = 2'b00;
  localparam logic [1:0] PC_EPC     = 2'b01;
  localparam logic [1:0] PC_TRAP    = 2'b10;
  localparam logic [1:0] PC_NEXT    = 2'b11;

  localparam logic [4:0]  OPCODE_SYSTEM = 5'b11100;
  localparam logic [2:0]  FUNCT3_PRIV   = 3'b000;
  localparam logic [11:0] FUNCT12_ECALL  = 12'h000;
  localparam logic [11:0] FUNCT12_EBREAK = 12'h001;
  localparam logic [11:0] FUNCT12_MRET   = 12'h302;

endpackage

// File: rtl/msrv32_machine_control_if.sv
// Bundle of the trap controller's decoder/CSR-facing signals; master is the
// controller side, slave is the decoder/CSR file side.
interface msrv32_machine_control_if;

  logic        illegal_instr_in;
  logic        misaligned_load_in;
  logic        misaligned_store_in;
  logic        misaligned_instr_in;
  logic [4:0]  opcode_6_to_2_in;
  logic [2:0]  funct3_in;
  logic [11:0] funct12_in;
  logic        mie_in;
  logic        meie_in;
  logic        mtie_in;
  logic        msie_in;
  logic        e_irq_in;
  logic        t_irq_in;
  logic        s_irq_in;

  logic        trap_taken_out;
  logic        i_or_e_out;
  logic [3:0]  cause_out;
  logic        set_cause_out;
  logic        set_epc_out;
  logic        mie_clear_out;
  logic        mie_set_out;
  logic        instret_inc_out;
  logic [1:0]  pc_src_out;
  logic        flush_out;

  modport master (
    input  illegal_instr_in, misaligned_load_in, misaligned_store_in, misaligned_instr_in,
    input  opcode_6_to_2_in, funct3_in, funct12_in,
    input  mie_in, meie_in, mtie_in, msie_in, e_irq_in, t_irq_in, s_irq_in,
    output trap_taken_out, i_or_e_out, cause_out, set_cause_out, set_epc_out,
    output mie_clear_out, mie_set_out, instret_inc_out, pc_src_out, flush_out
  );

  modport slave (
    output illegal_instr_in, misaligned_load_in, misaligned_store_in, misaligned_instr_in,
    output opcode_6_to_2_in, funct3_in, funct12_in,
    output mie_in, meie_in, mtie_in, msie_in, e_irq_in, t_irq_in, s_irq_in,
    input  trap_taken_out, i_or_e_out, cause_out, set_cause_out, set_epc_out,
    input  mie_clear_out, mie_set_out, instret_inc_out, pc_src_out, flush_out
  );

endinterface

// File: rtl/msrv32_trap_prio.sv
// Combinational trap priority encoder: any enabled interrupt beats any
// exception; within each class the first active source in the chain wins.
module msrv32_trap_prio
  import msrv32_pkg::*;
(
  input  logic       mie,
  input  logic       meie,
  input  logic       mtie,
  input  logic       msie,
  input  logic       e_irq,
  input  logic       t_irq,
  input  logic       s_irq,
  input  logic       misaligned_instr,
  input  logic       illegal_instr,
  input  logic       is_ebreak,
  input  logic       is_ecall,
  input  logic       misaligned_load,
  input  logic       misaligned_store,
  output logic       trap_req,
  output logic       is_irq,
  output logic [3:0] cause
);

  logic ext_pend, sw_pend, tmr_pend, irq_pend, exc_pend;

  assign ext_pend = mie & meie & e_irq;
  assign sw_pend  = mie & msie & s_irq;
  assign tmr_pend = mie & mtie & t_irq;
  assign irq_pend = ext_pend | sw_pend | tmr_pend;
  assign exc_pend = misaligned_instr | illegal_instr | is_ebreak | is_ecall
                  | misaligned_load | misaligned_store;

  assign trap_req = irq_pend | exc_pend;
  assign is_irq   = irq_pend;

  always_comb begin
    cause = CAUSE_INSTR_MISALIGNED;
    if      (ext_pend)         cause = CAUSE_M_EXT_IRQ;
    else if (sw_pend)          cause = CAUSE_M_SW_IRQ;
    else if (tmr_pend)         cause = CAUSE_M_TIMER_IRQ;
    else if (misaligned_instr) cause = CAUSE_INSTR_MISALIGNED;
    else if (illegal_instr)    cause = CAUSE_ILLEGAL_INSTR;
    else if (is_ebreak)        cause = CAUSE_BREAKPOINT;
    else if (is_ecall)         cause = CAUSE_ECALL_M;
    else if (misaligned_load)  cause = CAUSE_LOAD_MISALIGNED;
    else if (misaligned_store) cause = CAUSE_STORE_MISALIGNED;
  end

endmodule

// File: rtl/msrv32_machine_control.sv
// Machine-mode trap/return sequencer: a four-state FSM that latches the trap
// cause on entry and decodes PC-select, flush and CSR strobes from its state.
module msrv32_machine_control
  import msrv32_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        illegal_instr_in,
  input  logic        misaligned_load_in,
  input  logic        misaligned_store_in,
  input  logic        misaligned_instr_in,
  input  logic [4:0]  opcode_6_to_2_in,
  input  logic [2:0]  funct3_in,
  input  logic [11:0] funct12_in,
  input  logic        mie_in,
  input  logic        meie_in,
  input  logic        mtie_in,
  input  logic        msie_in,
  input  logic        e_irq_in,
  input  logic        t_irq_in,
  input  logic        s_irq_in,
  output logic        trap_taken_out,
  output logic        i_or_e_out,
  output logic [3:0]  cause_out,
  output logic        set_cause_out,
  output logic        set_epc_out,
  output logic        mie_clear_out,
  output logic        mie_set_out,
  output logic        instret_inc_out,
  output logic [1:0]  pc_src_out,
  output logic        flush_out
);

  logic       is_priv, is_ecall, is_ebreak, is_mret;
  logic       trap_req, is_irq;
  logic [3:0] cause;

  state_t     state_reg, state_next;
  logic [3:0] cause_reg;
  logic       i_or_e_reg;

  assign is_priv   = (opcode_6_to_2_in == OPCODE_SYSTEM) && (funct3_in == FUNCT3_PRIV);
  assign is_ecall  = is_priv && (funct12_in == FUNCT12_ECALL);
  assign is_ebreak = is_priv && (funct12_in == FUNCT12_EBREAK);
  assign is_mret   = is_priv && (funct12_in == FUNCT12_MRET);

  msrv32_trap_prio u_trap_prio (
    .mie              (mie_in),
    .meie             (meie_in),
    .mtie             (mtie_in),
    .msie             (msie_in),
    .e_irq            (e_irq_in),
    .t_irq            (t_irq_in),
    .s_irq            (s_irq_in),
    .misaligned_instr (misaligned_instr_in),
    .illegal_instr    (illegal_instr_in),
    .is_ebreak        (is_ebreak),
    .is_ecall         (is_ecall),
    .misaligned_load  (misaligned_load_in),
    .misaligned_store (misaligned_store_in),
    .trap_req         (trap_req),
    .is_irq           (is_irq),
    .cause            (cause)
  );

  // Cause is captured only on trap entry so mcause can be written while the
  // trap inputs have already moved on.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg  <= ST_RESET;
      cause_reg  <= 4'd0;
      i_or_e_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_OPERATING && trap_req) begin
        cause_reg  <= cause;
        i_or_e_reg <= is_irq;
      end
    end
  end

  assign cause_out  = cause_reg;
  assign i_or_e_out = i_or_e_reg;

  always_comb begin
    state_next      = ST_RESET;
    trap_taken_out  = 1'b0;
    set_cause_out   = 1'b0;
    set_epc_out     = 1'b0;
    mie_clear_out   = 1'b0;
    mie_set_out     = 1'b0;
    instret_inc_out = 1'b0;
    pc_src_out      = PC_BOOT;
    flush_out       = 1'b1;
    case (state_reg)
      ST_RESET: begin
        state_next = ST_OPERATING;
      end
      ST_OPERATING: begin
        // A trap always beats a coincident MRET.
        if (trap_req)     state_next = ST_TRAP_TAKEN;
        else if (is_mret) state_next = ST_TRAP_RETURN;
        else              state_next = ST_OPERATING;
        pc_src_out      = PC_NEXT;
        flush_out       = 1'b0;
        instret_inc_out = ~trap_req;
      end
      ST_TRAP_TAKEN: begin
        state_next     = ST_OPERATING;
        trap_taken_out = 1'b1;
        set_cause_out  = 1'b1;
        set_epc_out    = 1'b1;
        mie_clear_out  = 1'b1;
        pc_src_out     = PC_TRAP;
      end
      ST_TRAP_RETURN: begin
        state_next  = ST_OPERATING;
        mie_set_out = 1'b1;
        pc_src_out  = PC_EPC;
      end
      default: begin
        state_next = ST_RESET;
      end
    endcase
  end

endmodule

// File: tb/tb_msrv32_machine_control.sv
// Directed and randomized bench for msrv32_machine_control against a
// table-driven behavioural model of the trap rules.
module tb_msrv32_machine_control;

  localparam int S_RST = 0, S_OP = 1, S_TT = 2, S_TR = 3;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  int         m_state;
  logic [3:0] m_cause;
  bit         m_irq;

  msrv32_machine_control_if bus();

  msrv32_machine_control dut (
    .clk_in              (clk),
    .rst_n_in            (rst_n),
    .illegal_instr_in    (bus.illegal_instr_in),
    .misaligned_load_in  (bus.misaligned_load_in),
    .misaligned_store_in (bus.misaligned_store_in),
    .misaligned_instr_in (bus.misaligned_instr_in),
    .opcode_6_to_2_in    (bus.opcode_6_to_2_in),
    .funct3_in           (bus.funct3_in),
    .funct12_in          (bus.funct12_in),
    .mie_in              (bus.mie_in),
    .meie_in             (bus.meie_in),
    .mtie_in             (bus.mtie_in),
    .msie_in             (bus.msie_in),
    .e_irq_in            (bus.e_irq_in),
    .t_irq_in            (bus.t_irq_in),
    .s_irq_in            (bus.s_irq_in),
    .trap_taken_out      (bus.trap_taken_out),
    .i_or_e_out          (bus.i_or_e_out),
    .cause_out           (bus.cause_out),
    .set_cause_out       (bus.set_cause_out),
    .set_epc_out         (bus.set_epc_out),
    .mie_clear_out       (bus.mie_clear_out),
    .mie_set_out         (bus.mie_set_out),
    .instret_inc_out     (bus.instret_inc_out),
    .pc_src_out          (bus.pc_src_out),
    .flush_out           (bus.flush_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit sys_is(input logic [11:0] f12);
    return bus.opcode_6_to_2_in == 5'b11100 && bus.funct3_in == 3'b000 && bus.funct12_in == f12;
  endfunction

  // Scan the interrupt table, then the exception table, in priority order.
  function automatic void ref_prio(output bit req, output bit irq, output logic [3:0] cause);
    bit irq_act[3];
    int irq_code[3] = '{11, 3, 7};
    bit exc_act[6];
    int exc_code[6] = '{0, 2, 3, 11, 4, 6};
    irq_act = '{bus.mie_in & bus.meie_in & bus.e_irq_in,
                bus.mie_in & bus.msie_in & bus.s_irq_in,
                bus.mie_in & bus.mtie_in & bus.t_irq_in};
    exc_act = '{bus.misaligned_instr_in, bus.illegal_instr_in, sys_is(12'h001),
                sys_is(12'h000), bus.misaligned_load_in, bus.misaligned_store_in};
    req = 0; irq = 0; cause = 4'd0;
    for (int i = 0; i < 3; i++)
      if (!req && irq_act[i]) begin req = 1; irq = 1; cause = 4'(irq_code[i]); end
    for (int i = 0; i < 6; i++)
      if (!req && exc_act[i]) begin req = 1; irq = 0; cause = 4'(exc_code[i]); end
  endfunction

  function automatic logic [13:0] exp_outs();
    bit req, irq;
    logic [3:0] c;
    logic tt, sc, se, mc, ms, ii, fl;
    logic [1:0] pc;
    ref_prio(req, irq, c);
    {tt, sc, se, mc, ms, ii} = '0;
    fl = 1; pc = 2'b00;
    case (m_state)
      S_OP: begin pc = 2'b11; fl = 0; ii = !req; end
      S_TT: begin tt = 1; sc = 1; se = 1; mc = 1; pc = 2'b10; end
      S_TR: begin ms = 1; pc = 2'b01; end
      default: ;
    endcase
    return {tt, m_irq, m_cause, sc, se, mc, ms, ii, pc, fl};
  endfunction

  task automatic check_outs(input string tag);
    logic [13:0] obs;
    obs = {bus.trap_taken_out, bus.i_or_e_out, bus.cause_out, bus.set_cause_out,
           bus.set_epc_out, bus.mie_clear_out, bus.mie_set_out, bus.instret_inc_out,
           bus.pc_src_out, bus.flush_out};
    check(tag, {18'd0, obs}, {18'd0, exp_outs()});
  endtask

  task automatic model_reset();
    m_state = S_RST; m_cause = 4'd0; m_irq = 0;
  endtask

  // Advance one clock; the model consumes the inputs present before the edge.
  task automatic step();
    bit req, irq, mret;
    logic [3:0] c;
    ref_prio(req, irq, c);
    mret = sys_is(12'h302);
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else case (m_state)
      S_RST: m_state = S_OP;
      S_OP: begin
        if (req) begin m_state = S_TT; m_cause = c; m_irq = irq; end
        else if (mret) m_state = S_TR;
      end
      default: m_state = S_OP;
    endcase
  endtask

  task automatic clear_inputs();
    bus.illegal_instr_in = 0; bus.misaligned_load_in = 0;
    bus.misaligned_store_in = 0; bus.misaligned_instr_in = 0;
    bus.opcode_6_to_2_in = 5'b01100; bus.funct3_in = 3'd0; bus.funct12_in = 12'd0;
    bus.mie_in = 0; bus.meie_in = 0; bus.mtie_in = 0; bus.msie_in = 0;
    bus.e_irq_in = 0; bus.t_irq_in = 0; bus.s_irq_in = 0;
  endtask

  task automatic drive_sys(input logic [11:0] f12);
    bus.opcode_6_to_2_in = 5'b11100; bus.funct3_in = 3'd0; bus.funct12_in = f12;
  endtask

  task automatic randomize_inputs();
    logic [11:0] f12_tab[4];
    f12_tab = '{12'h000, 12'h001, 12'h302, 12'h000};
    f12_tab[3] = 12'($urandom);
    bus.illegal_instr_in    = ($urandom_range(15) == 0);
    bus.misaligned_load_in  = ($urandom_range(15) == 0);
    bus.misaligned_store_in = ($urandom_range(15) == 0);
    bus.misaligned_instr_in = ($urandom_range(15) == 0);
    bus.opcode_6_to_2_in    = ($urandom_range(3) == 0) ? 5'b11100 : 5'($urandom);
    bus.funct3_in           = ($urandom_range(3) != 0) ? 3'd0 : 3'($urandom);
    bus.funct12_in          = f12_tab[$urandom_range(3)];
    {bus.mie_in, bus.meie_in, bus.mtie_in, bus.msie_in} = 4'($urandom);
    bus.e_irq_in = ($urandom_range(3) == 0);
    bus.t_irq_in = ($urandom_range(3) == 0);
    bus.s_irq_in = ($urandom_range(3) == 0);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    model_reset();
    clear_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #2;
    check_outs("reset_state");
    @(negedge clk); rst_n = 1; #1;
    check("boot_pc_src", {30'd0, bus.pc_src_out}, 32'd0);
    check_outs("boot_cycle");

    step(); #1;
    check_outs("operating");
    check("op_instret", {31'd0, bus.instret_inc_out}, 32'd1);

    // illegal + load misaligned: illegal wins with cause 2
    bus.illegal_instr_in = 1; bus.misaligned_load_in = 1; #1;
    check_outs("exc_sample");
    step(); clear_inputs(); #1;
    check_outs("exc_taken");
    check("exc_cause", {28'd0, bus.cause_out}, 32'd2);
    step(); #1;
    check_outs("exc_back_op");

    // enabled interrupts plus ECALL: external interrupt wins
    bus.mie_in = 1; bus.meie_in = 1; bus.mtie_in = 1; bus.e_irq_in = 1; bus.t_irq_in = 1;
    drive_sys(12'h000);
    step(); #1;
    check_outs("irq_taken");
    check("irq_cause", {27'd0, bus.i_or_e_out, bus.cause_out}, {27'd0, 1'b1, 4'd11});
    step(); bus.mie_in = 0; #1;
    check_outs("irq_masked_sample");
    step(); #1;
    check_outs("ecall_taken");
    check("ecall_cause", {27'd0, bus.i_or_e_out, bus.cause_out}, {27'd0, 1'b0, 4'd11});
    step(); clear_inputs(); #1;

    // MRET
    drive_sys(12'h302); #1;
    check_outs("mret_sample");
    step(); clear_inputs(); #1;
    check_outs("mret_return");
    check("mret_pc_src", {30'd0, bus.pc_src_out}, 32'd1);
    step(); #1;

    // trap pending during TRAP_TAKEN is ignored
    bus.illegal_instr_in = 1;
    step(); bus.illegal_instr_in = 0;
    bus.mie_in = 1; bus.msie_in = 1; bus.s_irq_in = 1; #1;
    check_outs("tt_with_pending");
    step(); clear_inputs(); #1;
    check_outs("tt_ignored");
    check("tt_ignored_cause", {28'd0, bus.cause_out}, 32'd2);

    // reset asserted mid-trap
    bus.misaligned_store_in = 1;
    step(); clear_inputs(); #1;
    check_outs("store_taken");
    rst_n = 0; #1;
    model_reset();
    check_outs("reset_mid_trap");
    check("reset_cause", {28'd0, bus.cause_out}, 32'd0);
    @(negedge clk); rst_n = 1;
    step(); #1;
    check_outs("after_reset");

    // randomized traffic with occasional asynchronous resets
    for (int n = 0; n < 3000; n++) begin
      randomize_inputs();
      #1;
      check_outs("rand");
      if ($urandom_range(199) == 0) begin
        rst_n = 0; #1;
        model_reset();
        check_outs("rand_reset");
        @(negedge clk); rst_n = 1;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
